// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared constants, fetch state enum and FIFO entry type for the fetch stage
package mips_fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] data;
        logic [INSTR_W-1:0] pc;
    } fifo_entry_t;

endpackage

// File: rtl/mips_fetch_fifo.sv
// rtl/mips_fetch_fifo.sv - in-order prefetch FIFO with flush and occupancy output
module mips_fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [INSTR_W-1:0]         push_data_i,
    input  logic [INSTR_W-1:0]         push_pc_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [INSTR_W-1:0]         head_data_o,
    output logic [INSTR_W-1:0]         head_pc_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    fifo_entry_t            mem_q [DEPTH];
    fifo_entry_t            head;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= '{data: push_data_i, pc: push_pc_i};
    end

    // Head reads as zero while empty so stale entries never leak onto the core interface.
    assign valid_o     = (count_q != '0);
    assign head        = valid_o ? mem_q[rd_ptr_q] : '0;
    assign head_data_o = head.data;
    assign head_pc_o   = head.pc;
    assign count_o     = count_q;

endmodule

// File: rtl/mips_fetch_stage.sv
// rtl/mips_fetch_stage.sv - MIPS fetch front end (PC, imem issue, prefetch FIFO); MIPS_FETCH_PERF_EN adds perf counters
module mips_fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          MEM_LAT_MAX = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef MIPS_FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    localparam int          OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int          OUT_W  = $clog2(MEM_LAT_MAX + 1);
    localparam logic [31:0] DEPTH_U = 32'(FIFO_DEPTH);
    localparam logic [31:0] LAT_U   = 32'(MEM_LAT_MAX);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OUT_W-1:0] discard_q, discard_d;
    logic [OCC_W-1:0] occ;
    logic [31:0]      redirect_tgt;
    logic             issue, drop, push, pop;

    assign redirect_tgt = redirect_pc & ~32'h3;

    always_comb begin
        // Request is held low during reset so the memory never sees a fetch before release.
        issue = reset && (state_q == FETCH)
             && ((32'(occ) + 32'(out_q)) < DEPTH_U)
             && (32'(out_q) < LAT_U);
        drop  = imem_rvalid && (discard_q != '0);
        push  = imem_rvalid && !drop && !redirect_valid;
        pop   = inst_valid && inst_ready && !redirect_valid;
        out_d = out_q + OUT_W'(issue) - OUT_W'(imem_rvalid);

        fetch_pc_d = issue ? fetch_pc_q + PC_STEP : fetch_pc_q;
        rsp_pc_d   = push  ? rsp_pc_q + PC_STEP   : rsp_pc_q;
        discard_d  = drop  ? discard_q - OUT_W'(1) : discard_q;
        state_d    = state_q;
        if (state_q == DRAIN && discard_d == '0) state_d = FETCH;

        // Everything still in flight after this cycle belongs to the old stream.
        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            discard_d  = out_d;
            state_d    = (out_d != '0) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            discard_q  <= discard_d;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;

    mips_fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clock),
        .rst_ni      (reset),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (imem_rdata),
        .push_pc_i   (rsp_pc_q),
        .pop_i       (pop),
        .valid_o     (inst_valid),
        .head_data_o (inst_data),
        .head_pc_o   (inst_pc),
        .count_o     (occ)
    );

`ifdef MIPS_FETCH_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (inst_valid && !inst_ready && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect_valid && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb/tb_mips_fetch_stage.sv - directed self-checking bench for mips_fetch_stage with an in-order latency memory model
module tb_mips_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    int          mq_due[$];
    logic [31:0] mq_addr[$];

    always #5 clock = ~clock;

    mips_fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef MIPS_FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a negedge: serve the response due this cycle, record this cycle's request, advance.
    task automatic step();
        #1;
        if (mq_due.size() > 0 && mq_due[0] == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~mq_addr[0];
            void'(mq_due.pop_front());
            void'(mq_addr.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        if (imem_req) begin
            mq_due.push_back(cyc + mem_lat);
            mq_addr.push_back(imem_addr);
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset(input int lat);
        reset          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        mq_due.delete();
        mq_addr.delete();
        mem_lat = lat;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        cyc   = 0;
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        @(negedge clock);
        #1;
        check("rst_req",   imem_req,   32'h0);
        check("rst_addr",  imem_addr,  32'h0);
        check("rst_valid", inst_valid, 32'h0);
        check("rst_data",  inst_data,  32'h0);
        check("rst_pc",    inst_pc,    32'h0);

        // Streaming with 1-cycle memory
        do_reset(1);
        inst_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            check("t1_req",   imem_req,   32'h1);
            check("t1_addr",  imem_addr,  32'(c * 4));
            check("t1_valid", inst_valid, 32'(c >= 2));
            if (c >= 2) begin
                check("t1_pc",   inst_pc,   32'((c - 2) * 4));
                check("t1_data", inst_data, ~32'((c - 2) * 4));
            end
            step();
        end

        // Backpressure: credit limit then in-order drain
        do_reset(1);
        inst_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("t2_req", imem_req, 32'(c < 4));
            if (c >= 2) begin
                check("t2_valid_hold", inst_valid, 32'h1);
                check("t2_pc_hold",    inst_pc,    32'h0);
            end
            step();
        end
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t2_drain_valid", inst_valid, 32'h1);
            check("t2_drain_pc",    inst_pc,    32'(k * 4));
            check("t2_drain_data",  inst_data,  ~32'(k * 4));
            step();
        end

        // Redirect with 3 requests in flight on a 3-cycle memory
        do_reset(3);
        inst_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            redirect_valid = (c == 2);
            redirect_pc    = 32'h100;
            if (c >= 3 && c <= 5) check("t3_drain_req", imem_req, 32'h0);
            if (c == 6) begin
                check("t3_restart_req",  imem_req,  32'h1);
                check("t3_restart_addr", imem_addr, 32'h100);
            end
            if (c >= 3 && c <= 9) check("t3_flushed_valid", inst_valid, 32'h0);
            if (c == 10) begin
                check("t3_new_valid", inst_valid, 32'h1);
                check("t3_new_pc",    inst_pc,    32'h100);
                check("t3_new_data",  inst_data,  ~32'h100);
            end
            step();
        end
        redirect_valid = 1'b0;

        // Unaligned redirect coincident with a response and a pop
        do_reset(1);
        inst_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            redirect_valid = (c == 4);
            redirect_pc    = 32'h203;
            if (c == 4) begin
                check("t4_pre_valid", inst_valid, 32'h1);
                check("t4_pre_pc",    inst_pc,    32'h8);
            end
            if (c == 5) begin
                check("t4_flush_valid", inst_valid, 32'h0);
                check("t4_drain_req",   imem_req,   32'h0);
            end
            if (c == 6) begin
                check("t4_restart_req",  imem_req,   32'h1);
                check("t4_restart_addr", imem_addr,  32'h200);
                check("t4_no_push",      inst_valid, 32'h0);
            end
            if (c == 8) begin
                check("t4_new_valid", inst_valid, 32'h1);
                check("t4_new_pc",    inst_pc,    32'h200);
            end
            step();
        end
        redirect_valid = 1'b0;

        // Asynchronous reset while draining
        do_reset(3);
        inst_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            redirect_valid = (c == 2);
            redirect_pc    = 32'h100;
            step();
        end
        redirect_valid = 1'b0;
        check("t5_drain_addr", imem_addr, 32'h100);
        check("t5_drain_req",  imem_req,  32'h0);
        reset = 1'b0;
        #1;
        check("t5_async_req",   imem_req,   32'h0);
        check("t5_async_addr",  imem_addr,  32'h0);
        check("t5_async_valid", inst_valid, 32'h0);
        check("t5_async_data",  inst_data,  32'h0);
        check("t5_async_pc",    inst_pc,    32'h0);
        do_reset(1);
        inst_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) begin
                check("t5_restart_req",  imem_req,  32'h1);
                check("t5_restart_addr", imem_addr, 32'h0);
            end
            if (c == 2) begin
                check("t5_first_valid", inst_valid, 32'h1);
                check("t5_first_pc",    inst_pc,    32'h0);
            end
            step();
        end

`ifdef MIPS_FETCH_PERF_EN
        do_reset(1);
        check("t6_stall_rst", perf_stall_cnt, 32'h0);
        check("t6_flush_rst", 32'(perf_flush_cnt), 32'h0);
        for (int c = 0; c < 13; c++) begin
            inst_ready     = (c >= 7);
            redirect_valid = (c == 8 || c == 9);
            redirect_pc    = (c == 8) ? 32'h40 : 32'h80;
            step();
        end
        redirect_valid = 1'b0;
        check("t6_stall_cnt", perf_stall_cnt, 32'd5);
        check("t6_flush_cnt", 32'(perf_flush_cnt), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction fetch front end, directly upstream of the MIPS decode/execute core.
- Owns the PC register and issues word reads to instruction memory.
- Buffers returned instructions in a small in-order prefetch FIFO.
- Hands instructions to the core over a valid/ready handshake; a core branch/jump redirect flushes the FIFO and restarts fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 4, prefetch entries (power of 2, >= 2).
- MEM_LAT_MAX, 4, maximum in-flight memory requests; bounds the outstanding counter.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request valid; always accepted, one per cycle.
- imem_addr  out  32  word-aligned read address.
- imem_rvalid  in  1  response valid; responses return in request order, >= 1 cycle later.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  core accepts head this cycle.
- inst_data  out  32  instruction at FIFO head.
- inst_pc  out  32  PC of the FIFO head instruction.
- redirect_valid  in  1  branch/jump taken, one-cycle pulse.
- redirect_pc  in  32  new target; bits [1:0] ignored (forced 0).

Behaviour:
- Reset (reset=0, async):
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0; state = FETCH.
  - Outputs imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0.
  - Reset mid-operation drops everything; late memory responses after release are ignored only if discard covers them, so the memory must be reset with the fetch stage.
- Issue rule in FETCH: imem_req=1 when occupancy + outstanding < FIFO_DEPTH and outstanding < MEM_LAT_MAX. imem_addr = fetch_pc. On issue, fetch_pc += 4 (wraps at 2^32) and outstanding += 1.
- Response: on imem_rvalid, outstanding -= 1.
  - If discard > 0: discard -= 1 and the data is dropped.
  - Otherwise push {imem_rdata, pc_tag} into the FIFO. pc_tag comes from a response-PC counter that increments by 4 per accepted response.
- Pop: on inst_valid && inst_ready, occupancy -= 1. Push and pop in the same cycle leave occupancy unchanged; a push into a full FIFO cannot occur because of the credit rule.
- inst_valid/inst_data/inst_pc are registered FIFO-head values. First instruction latency after reset = memory latency + 1 cycle.
- Redirect, in any state, takes priority over pop and push in that cycle:
  - FIFO cleared and inst_valid=0 next cycle.
  - discard += outstanding, counting an issue made in the same cycle and excluding a response arriving in the same cycle (that response is dropped directly).
  - fetch_pc and response-PC counter = {redirect_pc[31:2],2'b00}.
  - state -> DRAIN if the resulting discard > 0, else FETCH.
- DRAIN: imem_req=0. Return to FETCH the cycle after discard reaches 0. A redirect during DRAIN updates the target and stays in DRAIN.
- Handshake: inst_data/inst_pc stable while inst_valid=1 and inst_ready=0, except when a redirect flushes the head.
- Counters sized $clog2(FIFO_DEPTH+1) and $clog2(MEM_LAT_MAX+1); no overflow possible by construction.

Optional Feature:
- MIPS_FETCH_PERF_EN defined:
  - Adds outputs perf_stall_cnt[31:0] (cycles with inst_valid=1 and inst_ready=0) and perf_flush_cnt[15:0] (redirects seen).
  - Both reset to 0 and saturate at all-ones.
- MIPS_FETCH_PERF_EN undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package mips_fetch_pkg holds:
  - RESET_PC default, the INSTR_W=32 and PC_STEP=4 constants.
  - Fetch state enum {FETCH, DRAIN}.
  - Struct for the FIFO entry {data, pc}.
- One sub-module: mips_fetch_fifo, a synchronous FIFO with flush input and occupancy output, parameterised by FIFO_DEPTH.

Test Plan:
- Reset release with 1-cycle memory and inst_ready=1:
  - imem_addr sequence 0x0, 0x4, 0x8, …
  - First inst_valid at cycle 2 with inst_pc=0x0; one instruction per cycle thereafter.
- inst_ready=0 for 10 cycles, 1-cycle memory:
  - Exactly 4 requests issued, then imem_req=0.
  - inst_pc=0x0 held stable.
  - After ready=1: PCs 0x0, 0x4, 0x8, 0xC in order with no gap.
- 3-cycle memory, redirect to 0x100 while 3 requests outstanding:
  - 3 responses dropped; state DRAIN for 3 cycles.
  - Next imem_addr=0x100; next inst_pc=0x100.
- Redirect_pc=0x203 coincident with imem_rvalid and inst_ready=1:
  - Response dropped, no pop reported.
  - Fetch restarts at 0x200.
- Async reset asserted mid-DRAIN:
  - All outputs at reset values immediately, without waiting for a clock edge.
  - After release, fetch restarts at RESET_PC.
- With MIPS_FETCH_PERF_EN defined:
  - 5 stall cycles plus 2 redirects give perf_stall_cnt=5 and perf_flush_cnt=2.
